wisc_s15_data_mem: RTL and testbench
====================================

// Module: wisc_s15_data_mem
// PURPOSE
//  Responder side of the CPU data-memory port: accepts one load/store request
//  at a time from the WISC-S15 core, inserts LATENCY wait cycles, then returns
//  read data / write acknowledge with a one-cycle rdy pulse. Word-addressed
//  16-bit storage. Sits beside the CPU inside the top level; the core stalls
//  while busy is high.
// PARAMETERS
//  ADDR_W   10  index width; DEPTH = 2**ADDR_W words
//  LATENCY  2   cycles from request acceptance to rdy (legal 1..15)
// PORTS
//  clk       in   1   system clock, all state updates on rising edge
//  rst       in   1   synchronous, active-high reset
//  re        in   1   read request (sampled only in IDLE)
//  we        in   1   write request (sampled only in IDLE)
//  addr      in   16  word address; index = addr[ADDR_W-1:0]
//  wrt_data  in   16  store data
//  rd_data   out  16  load data, valid when rdy=1 for a read
//  rdy       out  1   one-cycle completion pulse (read or write)
//  busy      out  1   request in flight; core must hold off new requests
// BEHAVIOUR
//  - Reset (rst=1 at rising edge): state=IDLE, cnt=0, rdy=0, busy=0,
//    rd_data=16'h0000. Storage array NOT cleared. Takes priority over all.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: if (re|we) at edge -> latch op, addr index, wrt_data; busy=1 next
//      cycle; LATENCY==1 -> RESP, else WAIT with cnt=LATENCY-1. Else stay.
//    WAIT: cnt decrements each edge; when cnt reaches 1 -> RESP.
//    RESP: rdy=1 for exactly this cycle; busy=1; at edge -> IDLE.
//  - Latency: request sampled at edge N => rdy high during cycle after edge
//    N+LATENCY-1, i.e. rdy asserted LATENCY cycles after acceptance edge.
//  - Read: rd_data loaded from mem[latched index] on entry to RESP; holds
//    last value after rdy drops until next read completes.
//  - Write: mem[latched index] <= latched wrt_data at the RESP->IDLE edge
//    (commit coincides with end of rdy pulse); rd_data unchanged.
//  - re & we both 1 at acceptance: treated as write; rd_data unchanged.
//  - re/we/addr/wrt_data ignored while busy; inputs latched, so changes
//    mid-transaction have no effect.
//  - Back-to-back: new request may be sampled on the first IDLE edge after
//    RESP; minimum issue interval = LATENCY+1 cycles.
//  - Address wrap: upper addr bits [15:ADDR_W] ignored (aliasing).
//  - rst during WAIT/RESP: transaction aborted, no rdy, pending write NOT
//    committed; next cycle IDLE.
//  - busy = (state != IDLE); rdy = (state == RESP); both registered-state
//    decodes, no combinational path from inputs.
// TESTING
//  1. Reset: hold rst 2 cycles mid-idle -> rdy=0, busy=0, rd_data=0000.
//  2. Write/read, LATENCY=2: we,addr=0x0005,data=0xBEEF; then re addr=0x0005
//     -> each rdy exactly 2 cycles after acceptance, rd_data=0xBEEF.
//  3. Alias: write 0x1234 to addr 0x0403 (ADDR_W=10), read 0x0003 -> 0x1234.
//  4. Ignored while busy: during WAIT drive we,addr=0x0005,data=0x0000 ->
//     no new transaction, later read of 0x0005 still 0xBEEF.
//  5. Abort: write 0xAAAA to 0x0010 (holds 0x5555), assert rst in WAIT ->
//     no rdy, subsequent read of 0x0010 returns 0x5555.
//  6. re&we together at 0x0020 data 0x0F0F -> rdy after LATENCY, rd_data
//     unchanged, later read returns 0x0F0F; repeat with LATENCY=1 -> rdy
//     one cycle after acceptance.

Source files
------------

// File: rtl/wisc_s15_data_mem.sv
// ============================================================================
// wisc_s15_data_mem : fixed-latency word-addressed data memory responder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module wisc_s15_data_mem #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        rdy,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                op_wr;
  logic [ADDR_W-1:0]   idx;
  logic [15:0]         wdata;
  logic [15:0]         mem [DEPTH];

  logic                req;
  logic                rd_op;
  logic [ADDR_W-1:0]   rd_idx;
  logic                load_rd;

  assign req = re | we;

  // Upper address bits alias onto the array and are intentionally dropped.
  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[15:ADDR_W];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY==1 RESP is entered straight from IDLE, before the latches hold the request.
  assign rd_op   = (state == S_IDLE) ? (re & ~we) : ~op_wr;
  assign rd_idx  = (state == S_IDLE) ? addr[ADDR_W-1:0] : idx;
  assign load_rd = (state_nxt == S_RESP) && (state != S_RESP) && rd_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rd_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        op_wr <= we;
        idx   <= addr[ADDR_W-1:0];
        wdata <= wrt_data;
      end
      if (load_rd) begin
        rd_data <= mem[rd_idx];
      end
    end
  end

  // Store commits as the rdy pulse ends; a reset in RESP drops it.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && op_wr) begin
      mem[idx] <= wdata;
    end
  end

  assign busy = (state != S_IDLE);
  assign rdy  = (state == S_RESP);

endmodule

`default_nettype wire

// File: tb/tb_wisc_s15_data_mem.sv
// ============================================================================
// tb_wisc_s15_data_mem : checks the data memory at LATENCY=2 and LATENCY=1
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wisc_s15_data_mem;

  logic        clk = 1'b0;
  logic        rst2, re2, we2, rdy2, busy2;
  logic [15:0] addr2, wd2, rd2;
  logic        rst1, re1, we1, rdy1, busy1;
  logic [15:0] addr1, wd1, rd1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lat;
    logic [15:0] rd;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          l1;
    bit          r;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vt[12];

  always #5 clk = ~clk;

  wisc_s15_data_mem #(.ADDR_W(10), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .re(re2), .we(we2), .addr(addr2),
    .wrt_data(wd2), .rd_data(rd2), .rdy(rdy2), .busy(busy2)
  );

  wisc_s15_data_mem #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .re(re1), .we(we1), .addr(addr1),
    .wrt_data(wd1), .rd_data(rd1), .rdy(rdy1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit l1, input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    if (l1) begin
      re1 = r; we1 = w; addr1 = a; wd1 = d;
    end else begin
      re2 = r; we2 = w; addr2 = a; wd2 = d;
    end
  endtask

  function automatic logic o_rdy(bit l1);
    return l1 ? rdy1 : rdy2;
  endfunction

  function automatic logic o_busy(bit l1);
    return l1 ? busy1 : busy2;
  endfunction

  function automatic logic [15:0] o_rd(bit l1);
    return l1 ? rd1 : rd2;
  endfunction

  // Called on a falling edge; the request is accepted at the next rising edge.
  task automatic do_req(input bit l1, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd, input bit poke,
                        input string name);
    sb_t e;
    int  k;
    bit  got;
    e.lat = l1 ? 1 : 2;
    e.rd  = exp_rd;
    sb.push_back(e);
    drive(l1, r, w, a, d);
    @(negedge clk);
    drive(l1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk({name, "_busy"}, 16'(o_busy(l1)), 16'h0001);
    k   = 1;
    got = 1'b0;
    while (k <= 20 && !got) begin
      if (o_rdy(l1)) begin
        got = 1'b1;
        e   = sb.pop_front();
        chk({name, "_lat"}, 16'(k), 16'(e.lat));
        chk({name, "_rd"}, o_rd(l1), e.rd);
      end else begin
        if (poke && k == 1) drive(l1, 1'b0, 1'b1, a, 16'h0000);
        @(negedge clk);
        drive(l1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        k++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no rdy expected rdy within 20 cycles", name);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk({name, "_rdy_end"}, 16'(o_rdy(l1)), 16'h0000);
    chk({name, "_idle"}, 16'(o_busy(l1)), 16'h0000);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    rst2 = 1'b0;
    chk("rst_rdy2",  16'(rdy2),  16'h0000);
    chk("rst_busy2", 16'(busy2), 16'h0000);
    chk("rst_rd2",   rd2,        16'h0000);
    chk("rst_rdy1",  16'(rdy1),  16'h0000);
    chk("rst_busy1", 16'(busy1), 16'h0000);
    chk("rst_rd1",   rd1,        16'h0000);

    vt[0]  = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 16'h0403, 16'h1234, 16'hBEEF};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h0F0F, 16'h1234};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0F0F};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h0F0F, 16'h0000};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0F0F};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 16'hFC07, 16'hA5A5, 16'h0F0F};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'hA5A5};
    vt[10] = '{1'b0, 1'b0, 1'b1, 16'h03FF, 16'hC3C3, 16'h0F0F};
    vt[11] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hC3C3};

    for (int i = 0; i < 12; i++) begin
      do_req(vt[i].l1, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].exp_rd, 1'b0,
             $sformatf("vec%0d", i));
    end

    // A store driven during WAIT must be ignored.
    do_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b1, "poke_rd");
    do_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, "poke_chk");

    // Reset in WAIT aborts a pending store.
    do_req(1'b0, 1'b0, 1'b1, 16'h0010, 16'h5555, 16'hBEEF, 1'b0, "pre_abort2");
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'hAAAA);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("abort2_busy", 16'(busy2), 16'h0001);
    chk("abort2_wait_rdy", 16'(rdy2), 16'h0000);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("abort2_rdy",  16'(rdy2),  16'h0000);
    chk("abort2_busy_clr", 16'(busy2), 16'h0000);
    chk("abort2_rd",   rd2,        16'h0000);
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0, "post_abort2");

    // Reset in RESP (LATENCY=1) must also drop the store.
    do_req(1'b1, 1'b0, 1'b1, 16'h0030, 16'h1111, 16'hA5A5, 1'b0, "pre_abort1");
    drive(1'b1, 1'b0, 1'b1, 16'h0030, 16'h2222);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("abort1_resp_rdy", 16'(rdy1), 16'h0001);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("abort1_rdy",  16'(rdy1),  16'h0000);
    chk("abort1_busy", 16'(busy1), 16'h0000);
    chk("abort1_rd",   rd1,        16'h0000);
    do_req(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0, "post_abort1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
